// File: rtl/apb_arb_pkg.sv
// Shared types and constants for the APB master arbiter.
package apb_arb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } apb_state_e;

   localparam int unsigned DEF_NUM_REQ = 2;
   localparam int unsigned DEF_ADDR_W  = 32;
   localparam int unsigned DEF_DATA_W  = 32;
   localparam int unsigned DEF_TIMEOUT = 16;

   // Width of an index selecting one of n requesters (never below 1 bit).
   function automatic int unsigned owner_w(input int unsigned n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/apb_master_arbiter_rr_arbiter.sv
// Combinational round-robin grant; the priority pointer is held by the caller.
module rr_arbiter #(
   parameter int unsigned N  = 2,
   parameter int unsigned IW = 1
) (
   input  logic          en_i,
   input  logic [N-1:0]  req_i,
   input  logic [IW-1:0] last_i,
   output logic [N-1:0]  gnt_o,
   output logic [IW-1:0] idx_o,
   output logic          valid_o
);

   int unsigned cand;

   // Search from last_i+1 (mod N); the first asserted request wins.
   always_comb begin
      gnt_o   = '0;
      idx_o   = '0;
      valid_o = 1'b0;
      cand    = 0;
      for (int unsigned i = 1; i <= N; i++) begin
         cand = int'(unsigned'(last_i)) + i;
         if (cand >= N) cand = cand - N;
         if (en_i && !valid_o && req_i[cand]) begin
            valid_o = 1'b1;
            idx_o   = IW'(cand);
         end
      end
      if (valid_o) gnt_o = N'(1) << idx_o;
   end

endmodule

// File: rtl/apb_master_arbiter.sv
// Shares one APB3 master port between NUM_REQ requesters with round-robin
// arbitration, wait-state support and a per-transfer ACCESS timeout.
module apb_master_arbiter
   import apb_arb_pkg::*;
#(
   parameter int unsigned NUM_REQ = DEF_NUM_REQ,
   parameter int unsigned ADDR_W  = DEF_ADDR_W,
   parameter int unsigned DATA_W  = DEF_DATA_W,
   parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
   input  logic                           pclk,
   input  logic                           preset_n,
   input  logic [NUM_REQ-1:0]             req_valid,
   output logic [NUM_REQ-1:0]             req_ready,
   input  logic [NUM_REQ-1:0]             req_write,
   input  logic [NUM_REQ-1:0][ADDR_W-1:0] req_addr,
   input  logic [NUM_REQ-1:0][DATA_W-1:0] req_wdata,
   output logic [NUM_REQ-1:0]             rsp_valid,
   output logic [DATA_W-1:0]              rsp_rdata,
   output logic                           rsp_err,
   output logic                           psel,
   output logic                           penable,
   output logic                           pwrite,
   output logic [ADDR_W-1:0]              paddr,
   output logic [DATA_W-1:0]              pwdata,
   input  logic [DATA_W-1:0]              prdata,
   input  logic                           pready
);

   localparam int unsigned IW    = owner_w(NUM_REQ);
   localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

   apb_state_e          state_q;
   logic [IW-1:0]       owner_q;
   logic [IW-1:0]       last_q;
   logic [CNT_W-1:0]    cnt_q;
   logic                psel_q, penable_q, pwrite_q, rsp_err_q;
   logic [ADDR_W-1:0]   paddr_q;
   logic [DATA_W-1:0]   pwdata_q, rsp_rdata_q;
   logic [NUM_REQ-1:0]  rsp_valid_q;

   logic                timeout_hit;
   logic                complete;
   logic                slot;
   logic [NUM_REQ-1:0]  gnt;
   logic [IW-1:0]       gnt_idx;
   logic                gnt_valid;

   // Completion and arbitration-slot qualification for the current cycle.
   always_comb begin
      timeout_hit = (TIMEOUT != 0) && (state_q == ACCESS) && !pready && (cnt_q == TO_LAST);
      complete    = (state_q == ACCESS) && (pready || timeout_hit);
      slot        = (state_q == IDLE) || complete;
   end

   rr_arbiter #(
      .N  (NUM_REQ),
      .IW (IW)
   ) u_rr (
      .en_i    (slot),
      .req_i   (req_valid),
      .last_i  (last_q),
      .gnt_o   (gnt),
      .idx_o   (gnt_idx),
      .valid_o (gnt_valid)
   );

   assign req_ready = gnt;

   // APB phase sequencer with registered bus and response outputs.
   always_ff @(posedge pclk or negedge preset_n) begin
      if (!preset_n) begin
         state_q     <= IDLE;
         owner_q     <= '0;
         last_q      <= IW'(NUM_REQ - 1);
         cnt_q       <= '0;
         psel_q      <= 1'b0;
         penable_q   <= 1'b0;
         pwrite_q    <= 1'b0;
         paddr_q     <= '0;
         pwdata_q    <= '0;
         rsp_valid_q <= '0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
      end else begin
         rsp_valid_q <= '0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
         case (state_q)
            IDLE: begin
               if (gnt_valid) begin
                  state_q  <= SETUP;
                  psel_q   <= 1'b1;
                  owner_q  <= gnt_idx;
                  last_q   <= gnt_idx;
                  pwrite_q <= req_write[gnt_idx];
                  paddr_q  <= req_addr[gnt_idx];
                  pwdata_q <= req_wdata[gnt_idx];
               end
            end
            SETUP: begin
               state_q   <= ACCESS;
               penable_q <= 1'b1;
               cnt_q     <= '0;
            end
            ACCESS: begin
               if (complete) begin
                  rsp_valid_q <= NUM_REQ'(1) << owner_q;
                  rsp_err_q   <= timeout_hit;
                  rsp_rdata_q <= (timeout_hit || pwrite_q) ? '0 : prdata;
                  penable_q   <= 1'b0;
                  // A grant in the completing cycle goes straight to SETUP,
                  // keeping psel high with no idle bubble.
                  if (gnt_valid) begin
                     state_q  <= SETUP;
                     owner_q  <= gnt_idx;
                     last_q   <= gnt_idx;
                     pwrite_q <= req_write[gnt_idx];
                     paddr_q  <= req_addr[gnt_idx];
                     pwdata_q <= req_wdata[gnt_idx];
                  end else begin
                     state_q <= IDLE;
                     psel_q  <= 1'b0;
                  end
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            default: begin
               state_q   <= IDLE;
               psel_q    <= 1'b0;
               penable_q <= 1'b0;
            end
         endcase
      end
   end

   assign psel      = psel_q;
   assign penable   = penable_q;
   assign pwrite    = pwrite_q;
   assign paddr     = paddr_q;
   assign pwdata    = pwdata_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_rdata_q;
   assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Directed self-checking bench for apb_master_arbiter (2 requesters, TIMEOUT=16).
module tb_apb_master_arbiter;

   logic             pclk = 1'b0;
   logic             preset_n = 1'b0;
   logic [1:0]       req_valid = '0;
   logic [1:0]       req_ready;
   logic [1:0]       req_write = '0;
   logic [1:0][31:0] req_addr = '0;
   logic [1:0][31:0] req_wdata = '0;
   logic [1:0]       rsp_valid;
   logic [31:0]      rsp_rdata;
   logic             rsp_err;
   logic             psel, penable, pwrite;
   logic [31:0]      paddr, pwdata;
   logic [31:0]      prdata;
   logic             pready;

   // Slave model: asserts pready after 'waits' ACCESS cycles unless hung.
   int unsigned waits = 0;
   logic        hang = 1'b0;
   logic [31:0] slave_rdata = '0;
   int unsigned acc_cnt = 0;

   int unsigned n_chk = 0;
   int unsigned n_pass = 0;

   assign prdata = slave_rdata;
   assign pready = psel & penable & ~hang & (acc_cnt >= waits);

   always @(posedge pclk) begin
      if (psel && penable && !pready) acc_cnt <= acc_cnt + 1;
      else acc_cnt <= 0;
   end

   always #5 pclk = ~pclk;

   apb_master_arbiter #(
      .NUM_REQ (2),
      .ADDR_W  (32),
      .DATA_W  (32),
      .TIMEOUT (16)
   ) dut (
      .pclk      (pclk),
      .preset_n  (preset_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_write (req_write),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .rsp_valid (rsp_valid),
      .rsp_rdata (rsp_rdata),
      .rsp_err   (rsp_err),
      .psel      (psel),
      .penable   (penable),
      .pwrite    (pwrite),
      .paddr     (paddr),
      .pwdata    (pwdata),
      .prdata    (prdata),
      .pready    (pready)
   );

   task automatic tick();
      @(posedge pclk);
      #1;
   endtask

   task automatic test_reset();
      preset_n = 1'b0;
      #2;
      n_chk++; if ({psel, penable, pwrite, rsp_err} !== 4'b0) $display("FAIL rst_ctrl: got %b exp 0000", {psel, penable, pwrite, rsp_err}); else n_pass++;
      n_chk++; if ({paddr, pwdata, rsp_rdata} !== 96'h0) $display("FAIL rst_data: got %h exp 0", {paddr, pwdata, rsp_rdata}); else n_pass++;
      n_chk++; if ({rsp_valid, req_ready} !== 4'b0) $display("FAIL rst_hs: got %b exp 0000", {rsp_valid, req_ready}); else n_pass++;
      tick();
      preset_n = 1'b1;
      tick();
      req_valid = 2'b11; req_write = 2'b00;
      req_addr[0] = 32'h0000_0010; req_addr[1] = 32'h0000_0020;
      #1;
      n_chk++; if (req_ready !== 2'b01) $display("FAIL rst_first_grant: got %b exp 01", req_ready); else n_pass++;
      tick();
      req_valid = 2'b00;
      n_chk++; if (paddr !== 32'h0000_0010) $display("FAIL rst_first_addr: got %h exp 00000010", paddr); else n_pass++;
      tick();
      tick();
      n_chk++; if (rsp_valid !== 2'b01) $display("FAIL rst_first_rsp: got %b exp 01", rsp_valid); else n_pass++;
   endtask

   task automatic test_single_write();
      waits = 0; slave_rdata = 32'h55AA_55AA;
      req_valid = 2'b01; req_write = 2'b01;
      req_addr[0] = 32'h0000_A000; req_wdata[0] = 32'h1234_5678;
      #1;
      n_chk++; if (req_ready !== 2'b01) $display("FAIL wr_ready: got %b exp 01", req_ready); else n_pass++;
      tick();
      req_valid = 2'b00; req_addr[0] = 32'hFFFF_FFFF; req_wdata[0] = '0;
      n_chk++; if ({psel, penable, pwrite} !== 3'b101) $display("FAIL wr_setup: got %b exp 101", {psel, penable, pwrite}); else n_pass++;
      n_chk++; if ({paddr, pwdata} !== {32'h0000_A000, 32'h1234_5678}) $display("FAIL wr_setup_bus: got %h exp 0000a00012345678", {paddr, pwdata}); else n_pass++;
      tick();
      n_chk++; if ({psel, penable, pready} !== 3'b111) $display("FAIL wr_access: got %b exp 111", {psel, penable, pready}); else n_pass++;
      n_chk++; if (paddr !== 32'h0000_A000) $display("FAIL wr_access_addr: got %h exp 0000a000", paddr); else n_pass++;
      n_chk++; if (rsp_valid !== 2'b00) $display("FAIL wr_no_early_rsp: got %b exp 00", rsp_valid); else n_pass++;
      tick();
      n_chk++; if ({rsp_valid, rsp_err} !== 3'b010) $display("FAIL wr_rsp: got %b exp 010", {rsp_valid, rsp_err}); else n_pass++;
      n_chk++; if (rsp_rdata !== 32'h0) $display("FAIL wr_rsp_rdata: got %h exp 00000000", rsp_rdata); else n_pass++;
      n_chk++; if (psel !== 1'b0) $display("FAIL wr_idle: got %b exp 0", psel); else n_pass++;
      tick();
      n_chk++; if (rsp_valid !== 2'b00) $display("FAIL wr_rsp_pulse: got %b exp 00", rsp_valid); else n_pass++;
   endtask

   task automatic test_read_wait();
      waits = 2; slave_rdata = 32'hDEAD_BEEF;
      req_valid = 2'b10; req_write = 2'b00; req_addr[1] = 32'h0000_0100;
      #1;
      n_chk++; if (req_ready !== 2'b10) $display("FAIL rd_ready: got %b exp 10", req_ready); else n_pass++;
      tick();
      req_valid = 2'b00;
      n_chk++; if ({psel, penable, pwrite} !== 3'b100) $display("FAIL rd_setup: got %b exp 100", {psel, penable, pwrite}); else n_pass++;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_chk++; if ({penable, pready} !== {1'b1, (i == 2)}) $display("FAIL rd_access%0d: got %b exp %b", i, {penable, pready}, {1'b1, (i == 2)}); else n_pass++;
         n_chk++; if (rsp_valid !== 2'b00) $display("FAIL rd_wait_rsp%0d: got %b exp 00", i, rsp_valid); else n_pass++;
      end
      tick();
      n_chk++; if ({rsp_valid, rsp_err} !== 3'b100) $display("FAIL rd_rsp: got %b exp 100", {rsp_valid, rsp_err}); else n_pass++;
      n_chk++; if (rsp_rdata !== 32'hDEAD_BEEF) $display("FAIL rd_rdata: got %h exp deadbeef", rsp_rdata); else n_pass++;
      waits = 0;
   endtask

   task automatic test_back_to_back();
      logic [1:0]  exp_gnt;
      logic [31:0] exp_addr;
      waits = 0; slave_rdata = 32'h0BAD_F00D;
      req_write = 2'b00;
      req_addr[0] = 32'h0000_1000; req_addr[1] = 32'h0000_2000;
      req_valid = 2'b11;
      #1;
      for (int k = 0; k < 4; k++) begin
         exp_gnt  = (k % 2 == 0) ? 2'b01 : 2'b10;
         exp_addr = (k % 2 == 0) ? 32'h0000_1000 + 32'(k / 2) * 32'h10
                                 : 32'h0000_2000 + 32'(k / 2) * 32'h10;
         n_chk++; if (req_ready !== exp_gnt) $display("FAIL b2b_grant%0d: got %b exp %b", k, req_ready, exp_gnt); else n_pass++;
         tick();
         n_chk++; if ({psel, penable} !== 2'b10) $display("FAIL b2b_setup%0d: got %b exp 10", k, {psel, penable}); else n_pass++;
         n_chk++; if (paddr !== exp_addr) $display("FAIL b2b_addr%0d: got %h exp %h", k, paddr, exp_addr); else n_pass++;
         if (k > 0) begin
            n_chk++; if (rsp_valid !== ~exp_gnt) $display("FAIL b2b_rsp%0d: got %b exp %b", k, rsp_valid, ~exp_gnt); else n_pass++;
         end
         if (exp_gnt[0]) req_addr[0] = req_addr[0] + 32'h10;
         else req_addr[1] = req_addr[1] + 32'h10;
         if (k == 3) req_valid = 2'b00;
         tick();
         n_chk++; if ({psel, penable} !== 2'b11) $display("FAIL b2b_access%0d: got %b exp 11", k, {psel, penable}); else n_pass++;
      end
      tick();
      n_chk++; if (rsp_valid !== 2'b10) $display("FAIL b2b_last_rsp: got %b exp 10", rsp_valid); else n_pass++;
      n_chk++; if (rsp_rdata !== 32'h0BAD_F00D) $display("FAIL b2b_rdata: got %h exp 0badf00d", rsp_rdata); else n_pass++;
      n_chk++; if (psel !== 1'b0) $display("FAIL b2b_idle: got %b exp 0", psel); else n_pass++;
   endtask

   task automatic test_timeout();
      int unsigned acc_seen;
      hang = 1'b1; slave_rdata = 32'hCAFE_CAFE;
      req_valid = 2'b01; req_write = 2'b00; req_addr[0] = 32'h0000_0300;
      #1;
      n_chk++; if (req_ready !== 2'b01) $display("FAIL to_ready: got %b exp 01", req_ready); else n_pass++;
      tick();
      req_valid = 2'b00;
      acc_seen = 0;
      for (int i = 0; i < 16; i++) begin
         tick();
         if (penable === 1'b1) acc_seen++;
         n_chk++; if (rsp_valid !== 2'b00) $display("FAIL to_early_rsp%0d: got %b exp 00", i, rsp_valid); else n_pass++;
      end
      n_chk++; if (acc_seen !== 16) $display("FAIL to_access_cycles: got %0d exp 16", acc_seen); else n_pass++;
      tick();
      n_chk++; if ({rsp_valid, rsp_err} !== 3'b011) $display("FAIL to_rsp: got %b exp 011", {rsp_valid, rsp_err}); else n_pass++;
      n_chk++; if (rsp_rdata !== 32'h0) $display("FAIL to_rdata: got %h exp 00000000", rsp_rdata); else n_pass++;
      n_chk++; if ({psel, penable} !== 2'b00) $display("FAIL to_idle: got %b exp 00", {psel, penable}); else n_pass++;
      hang = 1'b0;
   endtask

   task automatic test_reset_mid_access();
      logic [1:0] rsp_seen;
      hang = 1'b1; slave_rdata = 32'h7777_1111;
      req_valid = 2'b10; req_write = 2'b00; req_addr[1] = 32'h0000_0400;
      tick();
      req_valid = 2'b00;
      tick();
      tick();
      n_chk++; if ({psel, penable} !== 2'b11) $display("FAIL rm_in_access: got %b exp 11", {psel, penable}); else n_pass++;
      preset_n = 1'b0;
      #1;
      n_chk++; if ({psel, penable} !== 2'b00) $display("FAIL rm_bus_drop: got %b exp 00", {psel, penable}); else n_pass++;
      rsp_seen = '0;
      hang = 1'b0;
      tick();
      rsp_seen = rsp_seen | rsp_valid;
      preset_n = 1'b1;
      tick();
      rsp_seen = rsp_seen | rsp_valid;
      n_chk++; if (rsp_seen !== 2'b00) $display("FAIL rm_no_rsp: got %b exp 00", rsp_seen); else n_pass++;
      req_valid = 2'b10;
      #1;
      n_chk++; if (req_ready !== 2'b10) $display("FAIL rm_reissue_ready: got %b exp 10", req_ready); else n_pass++;
      tick();
      req_valid = 2'b00;
      tick();
      tick();
      n_chk++; if ({rsp_valid, rsp_err} !== 3'b100) $display("FAIL rm_reissue_rsp: got %b exp 100", {rsp_valid, rsp_err}); else n_pass++;
      n_chk++; if (rsp_rdata !== 32'h7777_1111) $display("FAIL rm_reissue_rdata: got %h exp 77771111", rsp_rdata); else n_pass++;
   endtask

   initial begin
      test_reset();
      test_single_write();
      test_read_wait();
      test_back_to_back();
      test_timeout();
      test_reset_mid_access();
      tick();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout exp finish");
      $fatal(1);
   end

endmodule

// File: doc/apb_master_arbiter.md
# apb_master_arbiter

Shares one APB3-style master port between `NUM_REQ` on-chip requesters and sequences each transfer through the APB SETUP/ACCESS phases. It sits between the requesters and the APB slaves. Each requester sees a simple valid/ready request channel and a one-cycle response pulse. The block supports back-to-back transfers, slave wait states and a per-transfer timeout.

## Interface
- `NUM_REQ`, 2: number of requesters (2..8).
- `ADDR_W`, 32: address width.
- `DATA_W`, 32: data width.
- `TIMEOUT`, 16: maximum ACCESS cycles with `pready` low before abort; 0 disables the timeout.

Ports (one clock; reset is asynchronous and active-low):
- `pclk`  in  1  clock.
- `preset_n`  in  1  asynchronous active-low reset.
- `req_valid`  in  NUM_REQ  per-requester request valid.
- `req_ready`  out  NUM_REQ  request accepted this cycle (one-hot or zero).
- `req_write`  in  NUM_REQ  1 = write, 0 = read.
- `req_addr`  in  NUM_REQ x ADDR_W  request address.
- `req_wdata`  in  NUM_REQ x DATA_W  write data.
- `rsp_valid`  out  NUM_REQ  one-cycle completion pulse to the owning requester.
- `rsp_rdata`  out  DATA_W  read data, shared, qualified by `rsp_valid`.
- `rsp_err`  out  1  completion was a timeout, qualified by `rsp_valid`.
- `psel`, `penable`, `pwrite`  out  1  APB control.
- `paddr`  out  ADDR_W  APB address.
- `pwdata`  out  DATA_W  APB write data.
- `prdata`  in  DATA_W  APB read data.
- `pready`  in  1  APB ready.

## Operation
- FSM states: IDLE, SETUP, ACCESS.
- **Arbitration slot:** a cycle in IDLE, or a cycle in ACCESS where the transfer completes (`pready`=1 or timeout).
- **Winner:** round-robin. Search starts at `last_grant+1` mod NUM_REQ; the first asserted `req_valid` wins.
- **Acceptance:** `req_ready[winner]`=1 combinationally in the slot. The request is latched into `paddr`/`pwrite`/`pwdata`, the owner index is stored, and `last_grant` is updated.
- **Requester rule:** a requester holds `req_valid` and its fields stable until `req_ready`. It may drop `req_valid` only after acceptance.
- **Transitions:**
  - IDLE → SETUP on acceptance.
  - SETUP → ACCESS unconditionally.
  - ACCESS stays while `pready`=0 and not timed out.
  - ACCESS → SETUP on completion when a new request is accepted in the same slot.
  - ACCESS → IDLE on completion when no request is pending.
- **Completion, normal:** `rsp_rdata` ← `prdata` (reads; 0 for writes) and `rsp_err` ← 0, sampled on the completing edge.
- **Completion, timeout:** `rsp_rdata` ← 0 and `rsp_err` ← 1.
- **Timeout counter:** cleared on entering ACCESS; increments each ACCESS cycle with `pready`=0. Timeout fires when the counter equals `TIMEOUT`-1 and `pready` is still 0.
- **Response:** `rsp_valid[owner]` pulses for exactly one cycle after completion, then clears.
- **Reset values:**
  - All outputs 0: `psel`, `penable`, `pwrite`, `paddr`, `pwdata`, `rsp_*`, `req_ready`.
  - State IDLE, `last_grant` = NUM_REQ-1, so requester 0 has first priority.
- **Reset mid-transfer:** the bus drops to idle immediately (asynchronous). No `rsp_valid` is issued for the aborted transfer.
- **`pready` outside ACCESS:** ignored.

## Timing
- **Minimum transfer:**
  - Acceptance at cycle 0.
  - SETUP at cycle 1 (`psel`=1, `penable`=0).
  - ACCESS at cycle 2 (`psel`=1, `penable`=1).
  - `rsp_valid` at cycle 3 if `pready`=1 in cycle 2.
- Each wait state adds one ACCESS cycle.
- **Back-to-back:** the next SETUP directly follows the completing ACCESS cycle, so `psel` stays 1 and `penable` drops for one cycle.
- `paddr`/`pwrite`/`pwdata` are constant from SETUP through the end of ACCESS.
- `psel`, `penable`, `paddr`, `pwrite`, `pwdata`, `rsp_*` are registered outputs. Only `req_ready` is combinational.

## Structure
- Package `apb_arb_pkg`:
  - `apb_state_e` enum (IDLE, SETUP, ACCESS).
  - Default width constants.
  - `clog2`-based owner-index width helper.
- Sub-module `rr_arbiter`: parameterised round-robin grant from the request vector and `last_grant`, plus an enable input. Purely combinational; the pointer register lives in the top.

## Test plan
- **Reset:** assert `preset_n`=0 mid-stream → all outputs 0 and state IDLE on the same cycle. After release, the first grant goes to requester 0 when 0 and 1 request together.
- **Single write:** req0 write addr 0x0000_A000, data 0x1234_5678, `pready` tied to `psel&penable` → SETUP at cycle 1, ACCESS at cycle 2, `rsp_valid[0]` at cycle 3 with `rsp_err`=0.
- **Read:** slave returns 0xDEAD_BEEF with 2 wait states → ACCESS lasts 3 cycles; `rsp_rdata`=0xDEAD_BEEF one cycle after `pready`.
- **Contention:** req0 and req1 hold `req_valid` continuously for 4 transfers → grant order 0,1,0,1. Back-to-back SETUP follows with no IDLE cycle; each `rsp_valid` goes only to its owner.
- **Timeout:** TIMEOUT=16, `pready` held 0 → abort after 16 ACCESS cycles; `rsp_err`=1, `rsp_rdata`=0; bus returns to IDLE.
- **Reset mid-ACCESS:** `preset_n` pulses low during a wait state → `psel`/`penable` drop immediately; no `rsp_valid`; the re-issued request completes normally.
